and_result_fifo: RTL

AND_RESULT_FIFO -- requirements
Module: and_result_fifo

---
 rtl/and_result_fifo.sv | 120 ++++++++++++
 1 files changed

// File: rtl/and_result_fifo.sv
// First-word-fall-through buffer for AND-stage result words, with occupancy
// state, popcount of the head word, a saturating zero-word counter and a sticky drop flag.
module and_result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(WIDTH+1)-1:0]   out_ones,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [7:0]                   zero_cnt,
  output logic                         drop,
  output logic [1:0]                   state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level_q, level_d;
  state_e           state_q, state_d;
  logic [7:0]       zero_cnt_q;
  logic             drop_q;
  logic             push, pop;

  // Handshake decodes depend only on the registered level, never on out_ready.
  assign in_ready  = (level_q < LW'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data = mem[rd_ptr];
  assign level    = level_q;
  assign zero_cnt = zero_cnt_q;
  assign drop     = drop_q;
  assign state    = state_q;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    out_ones = '0;
    if (out_valid) begin
      for (int i = 0; i < WIDTH; i++) begin
        out_ones = out_ones + OW'(out_data[i]);
      end
    end
  end

  // NOTE: storage is deliberately not reset; entries are unreachable until written.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (push) state_d = ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (push && !pop && level_q == LW'(DEPTH - 1)) begin
          state_d = ST_FULL;
        end else if (pop && !push && level_q == LW'(1)) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) state_d = ST_PARTIAL;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Pointers are AW bits wide, so DEPTH being a power of two gives the wrap for free.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      state_q    <= ST_EMPTY;
      zero_cnt_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      level_q <= level_d;
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && in_data == '0 && zero_cnt_q != 8'hFF) begin
        zero_cnt_q <= zero_cnt_q + 8'd1;
      end
      if (in_valid && !in_ready) drop_q <= 1'b1;
    end
  end

endmodule
